// File: rtl/spi_shift_framer.sv
// SPI word framer: shifts MOSI in on conditioned SCLK rise, shifts the tx word out on SCLK fall,
// and hands each completed word to the consumer through a valid/pending/ack handshake.
module spi_shift_framer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs_n,
    input  logic             sclk_posedge,
    input  logic             sclk_negedge,
    input  logic             mosi,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             rx_ack,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_pending,
    output logic             overrun,
    output logic             frame_abort,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_rx_en;
    logic             w_tx_en;
    logic             w_leave;
    logic             w_word_done;
    logic [WIDTH-1:0] w_rx_next;

    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] r_tx_shift;
    logic [WIDTH-1:0] r_rx_data;
    logic [CNT_W-1:0] r_bit_count;
    logic             r_rx_valid;
    logic             r_rx_pending;
    logic             r_overrun;
    logic             r_frame_abort;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; SCLK pulses only act while ACTIVE with cs_n still low, so the
    // entry and exit cycles ignore them
    always_comb begin
        w_state_next = r_state;
        w_rx_en      = 1'b0;
        w_tx_en      = 1'b0;
        w_leave      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!cs_n) begin
                    w_state_next = ST_ACTIVE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_n) begin
                    w_state_next = ST_IDLE;
                    w_leave      = 1'b1;
                end else begin
                    w_state_next = ST_ACTIVE;
                    w_rx_en      = sclk_posedge;
                    w_tx_en      = sclk_negedge;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_rx_next   = {r_rx_shift[WIDTH-2:0], mosi};
    assign w_word_done = w_rx_en && (r_bit_count == LP_LAST_BIT);

    // Receive shifter and bit counter; leaving the frame drops any partial word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_shift  <= '0;
            r_bit_count <= '0;
        end else if (w_leave) begin
            r_rx_shift  <= '0;
            r_bit_count <= '0;
        end else if (w_rx_en) begin
            r_rx_shift <= w_rx_next;
            if (w_word_done) begin
                r_bit_count <= '0;
            end else begin
                r_bit_count <= r_bit_count + LP_CNT_ONE;
            end
        end else begin
            r_rx_shift  <= r_rx_shift;
            r_bit_count <= r_bit_count;
        end
    end

    // Word hand-off, completion/abort pulses and handshake flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_pending  <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_rx_valid    <= w_word_done;
            r_frame_abort <= w_leave && (r_bit_count != '0);
            if (w_word_done) begin
                r_rx_data    <= w_rx_next;
                r_rx_pending <= 1'b1;
            end else if (rx_ack) begin
                r_rx_data    <= r_rx_data;
                r_rx_pending <= 1'b0;
            end else begin
                r_rx_data    <= r_rx_data;
                r_rx_pending <= r_rx_pending;
            end
            // An ack arriving with the new word counts as having consumed the old one
            if (w_word_done && r_rx_pending && !rx_ack) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    // Transmit shifter; a parallel load wins over a coincident SCLK fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_shift <= '0;
        end else if (load_en) begin
            r_tx_shift <= load_data;
        end else if (w_tx_en) begin
            r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
        end else begin
            r_tx_shift <= r_tx_shift;
        end
    end

    assign miso_oe     = (r_state == ST_ACTIVE);
    assign miso        = (r_state == ST_ACTIVE) & r_tx_shift[WIDTH-1];
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_pending  = r_rx_pending;
    assign overrun     = r_overrun;
    assign frame_abort = r_frame_abort;
    assign bit_count   = r_bit_count;

endmodule
